// File: rtl/operand_loader.sv
// operand_loader: debounced buttons load two 8-bit mux operands from sw and toggle the select.
// Optional auto-toggle of s while both operands are valid: define OPERAND_LOADER_AUTO_TOGGLE_EN.
module operand_loader #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TOGGLE_PERIOD   = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] sw,
  input  logic       btn_load_x,
  input  logic       btn_load_y,
  input  logic       btn_sel,
  output logic [7:0] x,
  output logic [7:0] y,
  output logic       s,
  output logic       x_valid,
  output logic       y_valid,
  output logic       ready
);
  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;
  localparam logic [16:0] DB = 17'(DEBOUNCE_CYCLES);
  logic [2:0] sync1_q, sync2_q, pulse;
  logic [7:0] x_q, y_q;
  logic       s_q, x_valid_q, y_valid_q, wrap;
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {btn_sel, btn_load_y, btn_load_x};
      sync2_q <= sync1_q;
    end
  end
  for (genvar i = 0; i < 3; i++) begin : g_db
    state_t      st_q;
    logic [15:0] cnt_q;
    logic [16:0] nxt;
    logic        up, enter_q, pulse_q;
    assign nxt = {1'b0, cnt_q} + 17'd1;
    assign up = (st_q == IDLE || st_q == PRESS_WAIT) && sync2_q[i] && nxt >= DB;
    assign pulse[i] = pulse_q;
    // the press pulse trails the HELD transition by one register stage
    always_ff @(posedge clk) begin
      if (reset) begin
        st_q    <= IDLE;
        cnt_q   <= '0;
        enter_q <= 1'b0;
        pulse_q <= 1'b0;
      end else begin
        enter_q <= up;
        pulse_q <= enter_q;
        if (st_q == IDLE || st_q == PRESS_WAIT) begin
          st_q  <= !sync2_q[i] ? IDLE : up ? HELD : PRESS_WAIT;
          cnt_q <= (!sync2_q[i] || up) ? '0 : nxt[15:0];
        end else begin
          st_q  <= sync2_q[i] ? HELD : nxt >= DB ? IDLE : RELEASE_WAIT;
          cnt_q <= (sync2_q[i] || nxt >= DB) ? '0 : nxt[15:0];
        end
      end
    end
  end
`ifdef OPERAND_LOADER_AUTO_TOGGLE_EN
  localparam logic [15:0] TP = 16'(TOGGLE_PERIOD);
  logic [15:0] tcnt_q;
  assign wrap = ready && (tcnt_q + 16'd1 == TP);
  always_ff @(posedge clk) begin
    if (reset) tcnt_q <= '0;
    else tcnt_q <= (ready && !wrap) ? tcnt_q + 16'd1 : '0;
  end
`else
  assign wrap = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      x_q       <= '0;
      y_q       <= '0;
      s_q       <= 1'b0;
      x_valid_q <= 1'b0;
      y_valid_q <= 1'b0;
    end else begin
      if (pulse[0]) begin
        x_q       <= sw;
        x_valid_q <= 1'b1;
      end
      if (pulse[1]) begin
        y_q       <= sw;
        y_valid_q <= 1'b1;
      end
      s_q <= s_q ^ (pulse[2] | wrap);
    end
  end
  assign x       = x_q;
  assign y       = y_q;
  assign s       = s_q;
  assign x_valid = x_valid_q;
  assign y_valid = y_valid_q;
  assign ready   = x_valid_q & y_valid_q;
endmodule
